// File: rtl/wb_ram_bridge.sv
// rtl/wb_ram_bridge.sv - Wishbone classic slave bridging management-bus accesses onto a req/gnt/rvalid RAM port.
// Holds one RAM transaction at a time; out-of-window accesses are acked locally without touching RAM.
module wb_ram_bridge #(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          DATA_WIDTH  = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          WINDOW_BITS = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [DATA_WIDTH-1:0] wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [DATA_WIDTH-1:0] wbs_dat_o,
  output logic                  req_o,
  input  logic                  gnt_i,
  input  logic                  rvalid_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  we_o,
  output logic [3:0]            be_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  input  logic [DATA_WIDTH-1:0] rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, ACK} state_t;

  state_t                state_q, state_d;
  logic                  ack_q, ack_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic                  req_q, req_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [3:0]            be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  abort_q, abort_d;

  logic                  in_window;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic                  unused_adr_lsb;

  assign in_window      = (wbs_adr_i[31:WINDOW_BITS] == BASE_ADDR[31:WINDOW_BITS]);
  assign unused_adr_lsb = ^wbs_adr_i[1:0];

  always_comb begin
    win_addr                  = '0;
    win_addr[WINDOW_BITS-1:2] = wbs_adr_i[WINDOW_BITS-1:2];
  end

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    dat_d   = dat_q;
    req_d   = req_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    abort_d = abort_q;
    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (wbs_cyc_i && wbs_stb_i) begin
          if (in_window) begin
            addr_d  = win_addr;
            we_d    = wbs_we_i;
            be_d    = wbs_sel_i;
            wdata_d = wbs_dat_i;
            req_d   = 1'b1;
            state_d = REQ;
          end else begin
            dat_d   = '0;
            ack_d   = 1'b1;
            state_d = ACK;
          end
        end
      end
      REQ: begin
        // A grant commits the RAM, so it wins over a simultaneous cycle drop.
        if (gnt_i) begin
          req_d   = 1'b0;
          abort_d = !wbs_cyc_i;
          state_d = WAIT;
        end else if (!wbs_cyc_i) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (rvalid_i) begin
          if (!we_q) dat_d = rdata_i;
          if (abort_q || !wbs_cyc_i) begin
            state_d = IDLE;
          end else begin
            ack_d   = 1'b1;
            state_d = ACK;
          end
        end else if (!wbs_cyc_i) begin
          abort_d = 1'b1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= 4'b0;
      wdata_q <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      abort_q <= abort_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign req_o     = req_q;
  assign addr_o    = addr_q;
  assign we_o      = we_q;
  assign be_o      = be_q;
  assign wdata_o   = wdata_q;

endmodule

// File: tb/tb_wb_ram_bridge.sv
// tb/tb_wb_ram_bridge.sv - randomized scoreboard bench for wb_ram_bridge with a transaction-level RAM reference.
module tb_wb_ram_bridge;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        req_o, gnt_i;
  logic        rvalid_i = 1'b0;
  logic [31:0] addr_o;
  logic        we_o;
  logic [3:0]  be_o;
  logic [31:0] wdata_o;
  logic [31:0] rdata_i = 32'h0;

  always #5 clk = ~clk;

  wb_ram_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .req_o(req_o), .gnt_i(gnt_i), .rvalid_i(rvalid_i),
    .addr_o(addr_o), .we_o(we_o), .be_o(be_o), .wdata_o(wdata_o), .rdata_i(rdata_i)
  );

  typedef struct { logic [31:0] dat; int cyc; } ack_t;
  typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } req_t;

  ack_t        aq[$];
  req_t        rq[$];
  int          total = 0;
  int          bad = 0;
  int          cnt = 0;
  int          gnt_delay = 0;
  int          wcnt = 0;
  logic        real_rv = 1'b0;
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  logic [31:0] last_dat = 32'h0;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic note_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s actual=event required=none", nm);
  endtask

  always @(posedge clk) cnt <= cnt + 1;

  // RAM model: grant after gnt_delay cycles of request, response one cycle later,
  // random spurious rvalid pulses in every other cycle.
  assign gnt_i = req_o && (wcnt >= gnt_delay);

  always @(posedge clk) begin
    if (!req_o || gnt_i) wcnt <= 0;
    else wcnt <= wcnt + 1;
    real_rv <= req_o && gnt_i;
    if (req_o && gnt_i) begin
      rvalid_i <= 1'b1;
      rdata_i  <= mem[addr_o[11:2]];
      if (we_o) mem[addr_o[11:2]] <= merge(mem[addr_o[11:2]], wdata_o, be_o);
    end else begin
      rvalid_i <= ($urandom_range(3) == 0);
      rdata_i  <= $urandom;
    end
  end

  logic        held = 1'b0;
  logic [31:0] h_addr, h_wdata;
  logic [3:0]  h_be;
  logic        h_we;

  always @(negedge clk) begin
    req_t e;
    if (req_o && held) begin
      chk("req_addr_stable", addr_o, h_addr);
      chk("req_wdata_stable", wdata_o, h_wdata);
      chk("req_ctl_stable", {27'b0, we_o, be_o}, {27'b0, h_we, h_be});
    end
    if (req_o && gnt_i) begin
      chk("outstanding", {31'b0, real_rv}, 32'h0);
      if (rq.size() == 0) note_fail("ram_unexpected_req");
      else begin
        e = rq.pop_front();
        chk("ram_addr", addr_o, e.addr);
        chk("ram_we", {31'b0, we_o}, {31'b0, e.we});
        if (e.we) begin
          chk("ram_be", {28'b0, be_o}, {28'b0, e.be});
          chk("ram_wdata", wdata_o, e.wdata);
        end
      end
    end
    held    <= req_o;
    h_addr  <= addr_o;
    h_wdata <= wdata_o;
    h_be    <= be_o;
    h_we    <= we_o;
  end

  always @(negedge clk) begin
    ack_t e;
    if (wbs_ack_o) begin
      if (aq.size() == 0) note_fail("ack_unexpected");
      else begin
        e = aq.pop_front();
        chk("ack_cycle", cnt, e.cyc);
        chk("ack_dat", wbs_dat_o, e.dat);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] adr, input logic we, input logic [3:0] sel, input logic [31:0] dat);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_sel_i = sel;
    wbs_adr_i = adr;
    wbs_dat_i = dat;
  endtask

  task automatic release_bus();
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after ack so the
  // next call re-asserts strobe immediately.
  task automatic access(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                        input logic [31:0] dat, input int gd);
    int off;
    int lat;
    bit got;
    off       = int'(adr[11:2]);
    gnt_delay = gd;
    if ((adr >> 12) == (BASE >> 12)) begin
      rq.push_back('{addr: {20'b0, adr[11:2], 2'b00}, we: we, be: sel, wdata: dat});
      if (we) ref_mem[off] = merge(ref_mem[off], dat, sel);
      else last_dat = ref_mem[off];
      lat = 3 + gd;
    end else begin
      last_dat = 32'h0;
      lat = 1;
    end
    aq.push_back('{dat: last_dat, cyc: cnt + lat});
    drive(adr, we, sel, dat);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = wbs_ack_o;
      @(posedge clk);
      #1;
    end
    if (!got) note_fail("ack_timeout");
    release_bus();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] w;
    for (int i = 0; i < 1024; i++) begin
      w = $urandom;
      mem[i] = w;
      ref_mem[i] = w;
    end
    mem[4]     = 32'hCAFE_BABE;
    ref_mem[4] = 32'hCAFE_BABE;
    rst_n = 1'b0;
    wbs_sel_i = 4'h0;
    wbs_adr_i = 32'h0;
    wbs_dat_i = 32'h0;
    release_bus();
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'b0, wbs_ack_o}, 32'h0);
    chk("rst_dat", wbs_dat_o, 32'h0);
    chk("rst_req", {31'b0, req_o}, 32'h0);
    chk("rst_addr", addr_o, 32'h0);
    chk("rst_we", {31'b0, we_o}, 32'h0);
    chk("rst_be", {28'b0, be_o}, 32'h0);
    chk("rst_wdata", wdata_o, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    access(32'h3000_0010, 1'b0, 4'hF, 32'h0, 0);
    idle(1);
    access(32'h3000_0024, 1'b1, 4'b0110, 32'h1234_5678, 5);
    idle(1);
    access(32'h3000_1000, 1'b0, 4'hF, 32'h0, 0);
    idle(1);
    access(32'h2000_0000, 1'b1, 4'hF, 32'hDEAD_BEEF, 0);
    idle(1);
    access(32'h3000_0013, 1'b0, 4'hF, 32'h0, 0);

    access(32'h3000_0024, 1'b0, 4'hF, 32'h0, 1);
    access(32'h3000_0010, 1'b1, 4'b1001, 32'hA5A5_5A5A, 0);
    access(32'h3000_0010, 1'b0, 4'hF, 32'h0, 2);
    idle(1);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(9) < 2) begin
        a = $urandom;
        if ((a >> 12) == (BASE >> 12)) a = a ^ 32'h8000_0000;
      end else begin
        a = BASE | 32'($urandom_range(4095));
      end
      access(a, 1'($urandom_range(1)), 4'($urandom_range(15)), $urandom, $urandom_range(4));
      if ($urandom_range(2) != 0) idle($urandom_range(2));
    end

    gnt_delay = 1000;
    drive(32'h3000_0040, 1'b0, 4'hF, 32'h0);
    idle(3);
    release_bus();
    @(negedge clk);
    chk("abort_req_held", {31'b0, req_o}, 32'h1);
    @(posedge clk);
    #1;
    chk("abort_req_low", {31'b0, req_o}, 32'h0);
    gnt_delay = 0;
    idle(3);
    access(32'h3000_0044, 1'b0, 4'hF, 32'h0, 0);
    idle(1);

    gnt_delay = 0;
    rq.push_back('{addr: 32'h48, we: 1'b0, be: 4'hF, wdata: 32'h0});
    drive(32'h3000_0048, 1'b0, 4'hF, 32'h0);
    idle(2);
    release_bus();
    idle(3);
    chk("abort_wait_req", {31'b0, req_o}, 32'h0);
    access(32'h3000_0010, 1'b0, 4'hF, 32'h0, 0);
    idle(1);

    rq.push_back('{addr: 32'h10, we: 1'b0, be: 4'hF, wdata: 32'h0});
    drive(32'h3000_0010, 1'b0, 4'hF, 32'h0);
    idle(2);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ack", {31'b0, wbs_ack_o}, 32'h0);
    chk("midrst_dat", wbs_dat_o, 32'h0);
    chk("midrst_req", {31'b0, req_o}, 32'h0);
    chk("midrst_addr", addr_o, 32'h0);
    chk("midrst_we", {31'b0, we_o}, 32'h0);
    chk("midrst_be", {28'b0, be_o}, 32'h0);
    chk("midrst_wdata", wdata_o, 32'h0);
    release_bus();
    last_dat = 32'h0;
    idle(1);
    rst_n = 1'b1;
    idle(1);
    access(32'h3000_0024, 1'b0, 4'hF, 32'h0, 0);

    idle(5);
    chk("ack_queue_empty", aq.size(), 32'h0);
    chk("req_queue_empty", rq.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
